// File: rtl/tx_port_fifo_pkg.sv
// -----------------------------------------------------------------------------
// tx_port_fifo_pkg
// Shared types and constants for the per-port egress frame FIFO.
//   TxFifoBus      : bundled fabric write-side signals
//   tx_rd_state_e  : read-side state machine encoding
//   TX_WORD_BYTES  : bytes per data word
//   DEF_MAX_FRAME_WORDS : default largest legal frame, in words
//   sat_inc32      : 32-bit saturating increment (statistics counters)
// -----------------------------------------------------------------------------
package tx_port_fifo_pkg;

  localparam int TX_WORD_BYTES       = 4;
  localparam int DEF_MAX_FRAME_WORDS = 384;

  typedef struct packed {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic [2:0]  bytes_valid;
    logic        commit;
    logic        drop;
  } TxFifoBus;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } tx_rd_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tx_port_fifo_len_fifo.sv
// -----------------------------------------------------------------------------
// tx_frame_len_fifo
// Single-clock FIFO of committed frame lengths (in words). The head entry is
// presented combinationally so the reader can load it on the start cycle.
// Empty/full flags are registered.
// Ports:
//   clk, rst_n : fabric clock, asynchronous active-low reset
//   i_push     : push i_data (accepted when not full, or when popping)
//   i_data     : frame length to enqueue
//   i_pop      : remove the head entry
//   o_head     : current head entry
//   o_empty    : registered empty flag (1 in reset)
//   o_full     : registered full flag
// -----------------------------------------------------------------------------
module tx_frame_len_fifo #(
  parameter int FRAME_DEPTH = 64,
  parameter int LEN_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [LEN_W-1:0] i_data,
  input  logic             i_pop,
  output logic [LEN_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int FA = $clog2(FRAME_DEPTH);
  localparam logic [FA:0] FULL_CNT = (FA+1)'(FRAME_DEPTH);

  logic [LEN_W-1:0] r_mem [FRAME_DEPTH];
  logic [FA-1:0]    r_wr_idx;
  logic [FA-1:0]    r_rd_idx;
  logic [FA:0]      r_cnt;
  logic             r_empty;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [FA:0]      w_cnt_nxt;

  assign w_pop     = i_pop && !r_empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_push    = i_push && (!r_full || w_pop);
  assign w_cnt_nxt = r_cnt + (FA+1)'(w_push) - (FA+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_idx] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + FA'(1);
      if (w_pop)  r_rd_idx <= r_rd_idx + FA'(1);
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == FULL_CNT);
    end
  end

  assign o_head  = r_mem[r_rd_idx];
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/tx_port_fifo.sv
// -----------------------------------------------------------------------------
// tx_port_fifo
// Per-port egress frame FIFO between the switch fabric and the egress MAC.
// Frames are written word by word and only become visible to the reader once
// committed; dropped, empty or oversized frames are rewound and never seen.
// Optional macro: TX_PORT_FIFO_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst_n        : fabric clock, asynchronous active-low reset
//   stat_clear        : (stats build) synchronous clear of the counters
//   stat_frames_committed / stat_frames_dropped / stat_overflow_words
//                     : (stats build) 32-bit saturating counters
//   wr_start          : first cycle of a new frame
//   wr_valid/wr_data/wr_bytes_valid : write word, big-endian, 1-4 bytes valid
//   wr_commit/wr_drop : publish / abort the frame in progress (drop wins)
//   wr_ready          : room for a maximum frame and a free length slot
//   frame_avail       : at least one committed frame queued
//   rd_start          : begin streaming the head frame
//   rd_valid/rd_data/rd_bytes_valid/rd_last : read stream, one word per cycle
// -----------------------------------------------------------------------------
module tx_port_fifo
  import tx_port_fifo_pkg::*;
#(
  parameter int DEPTH           = 2048,
  parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS,
  parameter int FRAME_DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TX_PORT_FIFO_STATS_EN
  input  logic        stat_clear,
  output logic [31:0] stat_frames_committed,
  output logic [31:0] stat_frames_dropped,
  output logic [31:0] stat_overflow_words,
`endif
  input  logic        wr_start,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_bytes_valid,
  input  logic        wr_commit,
  input  logic        wr_drop,
  output logic        wr_ready,
  output logic        frame_avail,
  input  logic        rd_start,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  rd_bytes_valid,
  output logic        rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_FRAME_WORDS + 1);
  localparam int MW = 3 + 32;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MAXW_P  = PW'(MAX_FRAME_WORDS);
  localparam logic [LW-1:0] MAXW_L  = LW'(MAX_FRAME_WORDS);

  TxFifoBus      w_bus;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_commit_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_wr_cnt;
  logic          r_ovf;
  logic          r_wr_ready;

  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] r_rd_q;

  tx_rd_state_e  r_state;
  tx_rd_state_e  w_state_nxt;
  logic [LW-1:0] r_rem;

  logic [PW-1:0] w_base_ptr;
  logic [LW-1:0] w_base_cnt;
  logic          w_base_ovf;
  logic          w_mem_full;
  logic          w_accept;
  logic          w_reject;
  logic [PW-1:0] w_new_ptr;
  logic [LW-1:0] w_new_cnt;
  logic          w_new_ovf;
  logic          w_commit_ok;
  logic          w_abort;
  logic [PW-1:0] w_free;

  logic          w_len_empty;
  logic          w_len_full;
  logic [LW-1:0] w_len_head;
  logic          w_rd_go;
  logic          w_last;
  logic          w_fetch;

  assign w_bus = '{start: wr_start, valid: wr_valid, data: wr_data,
                   bytes_valid: wr_bytes_valid, commit: wr_commit, drop: wr_drop};

  // ---- write side: resolve start, capacity and frame-size limits ----
  // wr_start rewinds to the last committed frame, so a coincident word lands
  // as word 0 of the new frame.
  assign w_base_ptr  = w_bus.start ? r_commit_ptr : r_wr_ptr;
  assign w_base_cnt  = w_bus.start ? '0 : r_wr_cnt;
  assign w_base_ovf  = w_bus.start ? 1'b0 : r_ovf;
  assign w_mem_full  = ((w_base_ptr - r_rd_ptr) == DEPTH_P);
  // Once overflow is flagged the rest of the frame is discarded.
  assign w_accept    = w_bus.valid && !w_base_ovf && (w_base_cnt != MAXW_L) && !w_mem_full;
  assign w_reject    = w_bus.valid && !w_accept;
  assign w_new_ptr   = w_base_ptr + PW'(w_accept);
  assign w_new_cnt   = w_base_cnt + LW'(w_accept);
  assign w_new_ovf   = w_base_ovf | w_reject;
  // Empty or overflowed frames, and commits with no length slot, rewind instead.
  assign w_commit_ok = w_bus.commit && !w_bus.drop && (w_new_cnt != '0) && !w_new_ovf &&
                       (!w_len_full || w_last);
  assign w_abort     = w_bus.drop || (w_bus.commit && !w_commit_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_wr_cnt     <= '0;
      r_ovf        <= 1'b0;
    end else if (w_commit_ok) begin
      r_wr_ptr     <= w_new_ptr;
      r_commit_ptr <= w_new_ptr;
      r_wr_cnt     <= '0;
      r_ovf        <= 1'b0;
    end else if (w_abort) begin
      r_wr_ptr     <= r_commit_ptr;
      r_wr_cnt     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_wr_ptr     <= w_new_ptr;
      r_wr_cnt     <= w_new_cnt;
      r_ovf        <= w_new_ovf;
    end
  end

  // ---- data RAM: simple dual-port, registered read ----
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_base_ptr[AW-1:0]] <= {w_bus.bytes_valid, w_bus.data};
    if (w_fetch)  r_rd_q <= r_mem[r_rd_ptr[AW-1:0]];
  end

  // ---- fabric ready: uncommitted words count as used space ----
  assign w_free = DEPTH_P - (r_wr_ptr - r_rd_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_ready <= 1'b0;
    else        r_wr_ready <= (w_free >= MAXW_P) && !w_len_full;
  end

  tx_frame_len_fifo #(
    .FRAME_DEPTH (FRAME_DEPTH),
    .LEN_W       (LW)
  ) u_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_commit_ok),
    .i_data  (w_new_cnt),
    .i_pop   (w_last),
    .o_head  (w_len_head),
    .o_empty (w_len_empty),
    .o_full  (w_len_full)
  );

  // ---- read side state machine ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RD_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (w_rd_go) w_state_nxt = RD_READ;
      RD_READ: if (w_last)  w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Fetch runs one word ahead of the output: the start cycle fetches word 0,
  // each streaming cycle fetches the next word unless the current one is last.
  always_comb begin
    w_rd_go = 1'b0;
    w_last  = 1'b0;
    w_fetch = 1'b0;
    case (r_state)
      RD_IDLE: begin
        w_rd_go = rd_start && !w_len_empty;
        w_fetch = w_rd_go;
      end
      RD_READ: begin
        w_last  = (r_rem == LW'(1));
        w_fetch = !w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_rem    <= '0;
    end else begin
      if (w_fetch) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_rd_go)                  r_rem <= w_len_head;
      else if (r_state == RD_READ)  r_rem <= r_rem - LW'(1);
    end
  end

  assign wr_ready       = r_wr_ready;
  assign frame_avail    = !w_len_empty;
  assign rd_valid       = (r_state == RD_READ);
  assign rd_last        = w_last;
  assign rd_data        = rd_valid ? r_rd_q[31:0] : '0;
  assign rd_bytes_valid = !rd_valid ? 3'd0 :
                          (w_last ? r_rd_q[34:32] : 3'(TX_WORD_BYTES));

`ifdef TX_PORT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_committed <= '0;
      stat_frames_dropped   <= '0;
      stat_overflow_words   <= '0;
    end else if (stat_clear) begin
      stat_frames_committed <= '0;
      stat_frames_dropped   <= '0;
      stat_overflow_words   <= '0;
    end else begin
      if (w_commit_ok) stat_frames_committed <= sat_inc32(stat_frames_committed);
      if (w_abort)     stat_frames_dropped   <= sat_inc32(stat_frames_dropped);
      if (w_reject)    stat_overflow_words   <= sat_inc32(stat_overflow_words);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tx_port_fifo.sv
module tb_tx_port_fifo;

  localparam int DEPTH = 2048;
  localparam int MAXW  = 384;
  localparam int FD    = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_start, wr_valid, wr_commit, wr_drop;
  logic [31:0] wr_data;
  logic [2:0]  wr_bytes_valid;
  logic        wr_ready, frame_avail, rd_start;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [2:0]  rd_bytes_valid;
`ifdef TX_PORT_FIFO_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_frames_committed, stat_frames_dropped, stat_overflow_words;
`endif

  int checks   = 0;
  int failures = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  tx_port_fifo #(.DEPTH(DEPTH), .MAX_FRAME_WORDS(MAXW), .FRAME_DEPTH(FD)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
`ifdef TX_PORT_FIFO_STATS_EN
    .stat_clear            (stat_clear),
    .stat_frames_committed (stat_frames_committed),
    .stat_frames_dropped   (stat_frames_dropped),
    .stat_overflow_words   (stat_overflow_words),
`endif
    .wr_start              (wr_start),
    .wr_valid              (wr_valid),
    .wr_data               (wr_data),
    .wr_bytes_valid        (wr_bytes_valid),
    .wr_commit             (wr_commit),
    .wr_drop               (wr_drop),
    .wr_ready              (wr_ready),
    .frame_avail           (frame_avail),
    .rd_start              (rd_start),
    .rd_valid              (rd_valid),
    .rd_data               (rd_data),
    .rd_bytes_valid        (rd_bytes_valid),
    .rd_last               (rd_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_start = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0; wr_drop = 1'b0;
    wr_data = '0; wr_bytes_valid = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " wr_ready"},       wr_ready, 0);
    check({tag, " frame_avail"},    frame_avail, 0);
    check({tag, " rd_valid"},       rd_valid, 0);
    check({tag, " rd_last"},        rd_last, 0);
    check({tag, " rd_data"},        rd_data, 0);
    check({tag, " rd_bytes_valid"}, rd_bytes_valid, 0);
  endtask

  // Drives an n-word frame; wr_start accompanies the first word.
  task automatic send_words(input int n, input logic [2:0] lastb, input bit commit,
                            input bit drop, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = $urandom;
      wr_start       = (i == 0);
      wr_valid       = 1'b1;
      wr_data        = d;
      wr_bytes_valid = (i == n - 1) ? lastb : 3'd4;
      wr_commit      = commit && (i == n - 1);
      wr_drop        = drop && (i == n - 1);
      if (expect_out) sb.push_back({(i == n - 1), wr_bytes_valid, d});
      step();
    end
    idle_inputs();
  endtask

  // Reads one frame and checks every word against the scoreboard.
  // ready_idx != 0: wr_ready must be 0 on that word and 1 on the next.
  task automatic read_frame(input string tag, input int ready_idx);
    int word;
    logic [35:0] exp;
    check({tag, " avail before start"}, frame_avail, 1);
    check({tag, " idle before start"}, rd_valid, 0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    word = 0;
    for (int c = 0; c < MAXW + 2; c++) begin
      if (!rd_valid) begin
        check({tag, " rd_valid gap"}, rd_valid, 1);
        break;
      end
      word++;
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      check({tag, " word"}, {rd_last, rd_bytes_valid, rd_data}, exp);
      if (ready_idx != 0 && word == ready_idx)     check({tag, " wr_ready low"},  wr_ready, 0);
      if (ready_idx != 0 && word == ready_idx + 1) check({tag, " wr_ready high"}, wr_ready, 1);
      if (rd_last) break;
      step();
    end
    step();
    check({tag, " valid after last"}, rd_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_start = 1'b0;
    idle_inputs();
`ifdef TX_PORT_FIFO_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
`ifdef TX_PORT_FIFO_STATS_EN
    check("reset stat_committed", stat_frames_committed, 0);
    check("reset stat_dropped",   stat_frames_dropped, 0);
    check("reset stat_ovf",       stat_overflow_words, 0);
`endif
    rst_n = 1'b1;
    check("wr_ready before first edge", wr_ready, 0);
    step();
    check("wr_ready after first edge", wr_ready, 1);

    // 16-word frame with a 2-byte final word
    check("t1 avail before commit", frame_avail, 0);
    send_words(16, 3'd2, 1'b1, 1'b0, 1'b1);
    check("t1 avail after commit", frame_avail, 1);
    read_frame("t1", 0);
    check("t1 avail after read", frame_avail, 0);

    // 10 words dropped, then a 5-word frame
    send_words(10, 3'd4, 1'b0, 1'b0, 1'b0);
    wr_drop = 1'b1;
    step();
    wr_drop = 1'b0;
    send_words(5, 3'd3, 1'b1, 1'b0, 1'b1);
    check("t2 free after drop", dut.w_free, DEPTH - 5);
    read_frame("t2", 0);
    check("t2 avail after read", frame_avail, 0);
    check("t2 scoreboard drained", sb.size(), 0);

    // 385-word frame: overflow turns the commit into a drop
    send_words(MAXW + 1, 3'd4, 1'b1, 1'b0, 1'b0);
    check("t3 avail after oversize", frame_avail, 0);
    step();
    check("t3 avail later", frame_avail, 0);
    check("t3 free restored", dut.w_free, DEPTH);
`ifdef TX_PORT_FIFO_STATS_EN
    check("t3 stat_committed", stat_frames_committed, 2);
    check("t3 stat_dropped",   stat_frames_dropped, 2);
    check("t3 stat_ovf",       stat_overflow_words, 1);
`endif

    // Fill with five maximum frames
    for (int f = 0; f < 5; f++) begin
      check("t4 ready before frame", wr_ready, 1);
      send_words(MAXW, 3'd4, 1'b1, 1'b0, 1'b1);
    end
    check("t4 ready after fill", wr_ready, 0);
    check("t4 free after fill", dut.w_free, DEPTH - 5 * MAXW);
    // free reaches MAXW once word 256 is showing; wr_ready follows a cycle later
    read_frame("t4 f0", 256);
    check("t4 ready after one read", wr_ready, 1);
    for (int f = 1; f < 5; f++) read_frame("t4 drain", 0);
    check("t4 avail after drain", frame_avail, 0);

    // commit and drop together: drop wins
    send_words(3, 3'd4, 1'b1, 1'b1, 1'b0);
    step();
    check("t5 avail after commit+drop", frame_avail, 0);
    check("t5 free after commit+drop", dut.w_free, DEPTH);
    // uncommitted words are discarded by the next wr_start
    send_words(4, 3'd4, 1'b0, 1'b0, 1'b0);
    send_words(3, 3'd1, 1'b1, 1'b0, 1'b1);
    read_frame("t5", 0);
    check("t5 scoreboard drained", sb.size(), 0);
`ifdef TX_PORT_FIFO_STATS_EN
    check("t5 stat_dropped", stat_frames_dropped, 3);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("stat_clear committed", stat_frames_committed, 0);
    check("stat_clear dropped",   stat_frames_dropped, 0);
    check("stat_clear ovf",       stat_overflow_words, 0);
`endif

    // reset in the middle of a read
    send_words(8, 3'd4, 1'b1, 1'b0, 1'b1);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    check("t6 streaming before reset", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6 mid-read reset");
    sb.delete();
    step();
    rst_n = 1'b1;
    check("t6 ready before edge", wr_ready, 0);
    check("t6 avail before edge", frame_avail, 0);
    step();
    check("t6 ready after edge", wr_ready, 1);
    check("t6 avail after edge", frame_avail, 0);
    check("t6 free after reset", dut.w_free, DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_port_fifo.md
Name: tx_port_fifo

Overview:
- Per-port egress frame FIFO. The switch fabric writes forwarded frames into it; one instance per port (28 total: 24 × 1G, 4 × 10G).
- Buffers complete frames with commit/drop semantics, so the MAC never sees a partial or aborted frame.
- Drives the fabric's per-port tx_fifo_ready bit. Sits between SwitchFabric and the egress MAC path.
- Single clock domain (fabric clock). Any MAC-side CDC is external.

Parameters:
- DEPTH, 2048: data words of storage. Must be a power of 2.
- MAX_FRAME_WORDS, 384: largest legal frame, in 32-bit words.
- FRAME_DEPTH, 64: maximum committed frames queued. Must be a power of 2.

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  asynchronous reset, active low
- wr_start  in  1  first cycle of a new frame
- wr_valid  in  1  wr_data is valid this cycle
- wr_data  in  32  frame data, big-endian byte order
- wr_bytes_valid  in  3  valid bytes in the word, 1-4; only the final word may be partial
- wr_commit  in  1  frame complete, publish it
- wr_drop  in  1  abort the frame in progress
- wr_ready  out  1  space for a full MAX_FRAME_WORDS frame and a free length slot; this is the tx_fifo_ready bit
- frame_avail  out  1  at least one committed frame queued
- rd_start  in  1  begin streaming the head frame
- rd_valid  out  1  rd_data is valid
- rd_data  out  32  frame data
- rd_bytes_valid  out  3  valid bytes in the word
- rd_last  out  1  final word of the frame

Behaviour:
- Reset (async, rst_n low):
  - All pointers, the length FIFO and the state machine return to zero/IDLE.
  - All outputs are 0, including wr_ready. wr_ready rises on the first clock edge after rst_n deasserts.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each log2(DEPTH)+1 bits, with the MSB used for wrap detection.
  - free = DEPTH - (wr_ptr - rd_ptr), modulo arithmetic.
  - wr_ready is registered: wr_ready <= (free >= MAX_FRAME_WORDS) && length FIFO not full.
- Write side:
  - wr_start: wr_ptr <= commit_ptr (silently discards any uncommitted words), word count <= 0, overflow flag cleared.
  - wr_valid: stores {bytes_valid, data} at wr_ptr, then wr_ptr++ and count++. When wr_start and wr_valid coincide, that word is the first word of the new frame.
  - Word number MAX_FRAME_WORDS+1 in the same frame is not stored and sets the overflow flag.
  - wr_commit: the frame's word count (including any wr_valid word in the same cycle) is pushed into the length FIFO; commit_ptr <= updated wr_ptr.
  - wr_commit with count 0, or with overflow set, is treated as a drop.
  - wr_drop: wr_ptr <= commit_ptr. If wr_commit and wr_drop are asserted together, drop wins.
  - Fabric contract: it starts a frame only while wr_ready=1. Writes while wr_ready=0 are still accepted up to physical capacity. Once full (free=0), further words set overflow and are discarded.
- Read side, state machine IDLE -> READ -> IDLE:
  - frame_avail is the registered "length FIFO not empty" flag. It updates one cycle after a commit.
  - IDLE: rd_start && frame_avail -> load the length into rd_remaining and go to READ. rd_start is ignored otherwise.
  - READ: memory has 1-cycle read latency. The first rd_valid comes the cycle after rd_start.
  - Streams exactly one word per cycle with no backpressure. rd_ptr++ per word.
  - rd_last is asserted on the final word. The length FIFO is popped on that same cycle and the machine returns to IDLE.
  - A new rd_start is accepted the cycle after rd_last.
- Simultaneous read and write are supported. A commit in the same cycle as the final-word pop keeps the length FIFO count correct (net zero change).
- rd_bytes_valid is 4 on every non-final word.

Optional Feature:
- TX_PORT_FIFO_STATS_EN defined:
  - Adds 32-bit saturating output counters: stat_frames_committed, stat_frames_dropped (explicit drop, empty frame, or overflow) and stat_overflow_words.
  - All three reset to 0 and have a stat_clear input that clears them synchronously.
- Undefined: none of these ports or logic exist.

Decomposition:
- Shared package TxFifoPkg:
  - TxFifoBus struct {start, valid, data[31:0], bytes_valid[2:0], commit, drop}.
  - Constants TX_WORD_BYTES=4 and default MAX_FRAME_WORDS.
- One sub-module: tx_frame_len_fifo, a single-clock FRAME_DEPTH × log2(MAX_FRAME_WORDS+1) FIFO with registered empty/full flags.
- Data RAM is inferred inline as a simple dual-port block RAM.

Test Plan:
- Reset, then write a 16-word frame (last word 2 bytes) and commit -> frame_avail=1 next cycle. rd_start -> 16 consecutive rd_valid words beginning the following cycle; rd_last on word 16 with rd_bytes_valid=2; frame_avail=0 afterwards.
- Write 10 words, wr_drop, then write and commit a 5-word frame -> only the 5-word frame is read back; free space equals DEPTH-5.
- 385-word frame committed -> frame discarded, frame_avail stays 0, wr_ptr restored (stats: dropped=1, overflow_words=1).
- Fill with 5 × 384-word frames (DEPTH=2048) -> wr_ready=0 after the 5th commit (free=128). Read one frame -> wr_ready=1 one cycle after free reaches 384.
- wr_commit and wr_drop in the same cycle -> drop; wr_start with wr_valid -> word counted as the first word of the new frame.
- Assert rst_n=0 mid-READ -> all outputs 0 immediately. After release: frame_avail=0, wr_ready=1 after one edge.
